// File: rtl/req_dispatch_pkg.sv
// Shared types and constants for the request dispatch stage.
// Holds the id encoding helper used by the dispatcher and its channels.
package req_dispatch_pkg;

    localparam int unsigned REQ_N = 12;
    localparam int unsigned ID_W  = 4;
    localparam logic [ID_W-1:0] ID_NONE = 4'h0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // id n (1..REQ_N) maps to bit n-1; id 0 and out-of-range ids map to nothing
    function automatic logic [REQ_N-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [REQ_N-1:0] oh;
        oh = '0;
        for (int i = 0; i < int'(REQ_N); i++) begin
            if (id == ID_W'(i + 1)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/req_chan.sv
// Single valid/ready service channel: holds an id until accepted,
// or drops it after TIMEOUT unaccepted valid cycles.
module req_chan
    import req_dispatch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            load_valid,
    input  logic [ID_W-1:0] load_id,
    input  logic            ready,
    output logic            valid,
    output logic [ID_W-1:0] id,
    output logic            accept_c,
    output logic            timeout_c
);

    localparam int unsigned WAIT_W = 16;

    logic [WAIT_W-1:0] wait_cnt;

    // Ready on the timeout edge counts as an accept
    assign accept_c  = valid && ready;
    assign timeout_c = valid && !ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            id       <= ID_NONE;
            wait_cnt <= '0;
        end else if (load) begin
            valid    <= load_valid;
            id       <= load_id;
            wait_cnt <= '0;
        end else if (accept_c || timeout_c) begin
            valid    <= 1'b0;
            wait_cnt <= '0;
        end else if (valid) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/req_dispatch.sv
// Collects sticky request lines into a pending vector and dispatches the
// two highest-priority ids from the external encoder on channels A and B.
module req_dispatch
    import req_dispatch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_N-1:0] req_i,
    output logic [REQ_N-1:0] pend_o,
    input  logic [ID_W-1:0]  first_i,
    input  logic [ID_W-1:0]  second_i,
    output logic             a_valid_o,
    output logic [ID_W-1:0]  a_id_o,
    input  logic             a_ready_i,
    output logic             b_valid_o,
    output logic [ID_W-1:0]  b_id_o,
    input  logic             b_ready_i,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] grant_cnt_o
);

    state_t           state;
    state_t           state_next;
    logic             capture_c;
    logic             b_load_valid_c;
    logic             a_acc_c;
    logic             b_acc_c;
    logic             a_to_c;
    logic             b_to_c;
    logic             a_hold_c;
    logic             b_hold_c;
    logic [REQ_N-1:0] clr_c;
    logic [REQ_N-1:0] requeue_c;
    logic [1:0]       grant_inc_c;

    req_chan #(.TIMEOUT(TIMEOUT)) u_chan_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (capture_c),
        .load_valid (1'b1),
        .load_id    (first_i),
        .ready      (a_ready_i),
        .valid      (a_valid_o),
        .id         (a_id_o),
        .accept_c   (a_acc_c),
        .timeout_c  (a_to_c)
    );

    req_chan #(.TIMEOUT(TIMEOUT)) u_chan_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (capture_c),
        .load_valid (b_load_valid_c),
        .load_id    (second_i),
        .ready      (b_ready_i),
        .valid      (b_valid_o),
        .id         (b_id_o),
        .accept_c   (b_acc_c),
        .timeout_c  (b_to_c)
    );

    assign b_load_valid_c = (second_i != ID_NONE) && (second_i != first_i);
    assign a_hold_c       = a_valid_o && !a_acc_c && !a_to_c;
    assign b_hold_c       = b_valid_o && !b_acc_c && !b_to_c;
    assign grant_inc_c    = 2'(a_acc_c) + 2'(b_acc_c);
    assign requeue_c      = (a_to_c ? id_to_onehot(a_id_o) : '0)
                          | (b_to_c ? id_to_onehot(b_id_o) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture in IDLE; leave ISSUE once neither channel is still holding
    always_comb begin
        state_next = state;
        capture_c  = 1'b0;
        clr_c      = '0;
        case (state)
            ST_IDLE: begin
                if (first_i != ID_NONE) begin
                    capture_c  = 1'b1;
                    clr_c      = id_to_onehot(first_i) | id_to_onehot(second_i);
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!a_hold_c && !b_hold_c) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // New requests and re-queues win over clears on the same bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_o      <= '0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
            grant_cnt_o <= '0;
        end else begin
            pend_o      <= (pend_o & ~clr_c) | req_i | requeue_c;
            busy_o      <= (state_next == ST_ISSUE);
            timeout_o   <= a_to_c || b_to_c;
            grant_cnt_o <= grant_cnt_o + CNT_W'(grant_inc_c);
        end
    end

endmodule

// File: tb/tb_req_dispatch.sv
// Bench for req_dispatch: directed vector table, hand-written reset corner,
// and randomized traffic against a transaction-level reference model.
module tb_req_dispatch;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic [11:0] req_i;
    logic [11:0] pend;
    logic [3:0]  first;
    logic [3:0]  second;
    logic        a_valid;
    logic [3:0]  a_id;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_id;
    logic        b_ready;
    logic        busy;
    logic        tmo;
    logic [7:0]  grant;

    int n_cmp = 0;
    int n_bad = 0;

    req_dispatch #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .pend_o      (pend),
        .first_i     (first),
        .second_i    (second),
        .a_valid_o   (a_valid),
        .a_id_o      (a_id),
        .a_ready_i   (a_ready),
        .b_valid_o   (b_valid),
        .b_id_o      (b_id),
        .b_ready_i   (b_ready),
        .busy_o      (busy),
        .timeout_o   (tmo),
        .grant_cnt_o (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment encoder: two highest set bits of the pending vector
    always_comb begin
        first  = 4'd0;
        second = 4'd0;
        for (int k = 11; k >= 0; k--) begin
            if (pend[k]) begin
                if (first == 4'd0)       first  = 4'(k + 1);
                else if (second == 4'd0) second = 4'(k + 1);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: outstanding ids with ages, pending set, grant tally
    logic [11:0] m_pend;
    bit          m_act [2];
    int          m_id  [2];
    int          m_age [2];
    int          m_grant;
    bit          m_to;

    task automatic model_reset();
        m_pend = '0;
        m_grant = 0;
        m_to = 0;
        for (int c = 0; c < 2; c++) begin
            m_act[c] = 0; m_id[c] = 0; m_age[c] = 0;
        end
    endtask

    task automatic model_step(input logic [11:0] req, input bit ra, input bit rb);
        logic [11:0] clr;
        logic [11:0] rq;
        bit          rdy [2];
        int          ids [$];
        clr = '0;
        rq  = '0;
        rdy[0] = ra;
        rdy[1] = rb;
        m_to = 0;
        if (!m_act[0] && !m_act[1]) begin
            for (int k = 12; k >= 1; k--) if (m_pend[k-1]) ids.push_back(k);
            if (ids.size() > 0) begin
                m_act[0] = 1; m_id[0] = ids[0]; m_age[0] = 0;
                clr[ids[0]-1] = 1'b1;
                m_age[1] = 0;
                if (ids.size() > 1) begin
                    m_act[1] = 1; m_id[1] = ids[1];
                    clr[ids[1]-1] = 1'b1;
                end else begin
                    m_act[1] = 0; m_id[1] = 0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (m_act[c]) begin
                    if (rdy[c]) begin
                        m_act[c] = 0; m_grant++;
                    end else if (m_age[c] == TO - 1) begin
                        m_act[c] = 0; rq[m_id[c]-1] = 1'b1; m_to = 1;
                    end else begin
                        m_age[c]++;
                    end
                end
            end
        end
        m_pend = (m_pend & ~clr) | req | rq;
    endtask

    task automatic tick(input logic [11:0] req, input logic ra, input logic rb, input bit use_model);
        req_i = req;
        a_ready = ra;
        b_ready = rb;
        if (use_model) model_step(req, ra, rb);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [11:0] req;
        logic        ra;
        logic        rb;
        logic [11:0] pend;
        logic        av;
        logic [3:0]  aid;
        logic        bv;
        logic [3:0]  bid;
        logic        busy;
        logic        to;
        logic [7:0]  grant;
    } vec_t;

    function automatic vec_t row(input logic [11:0] rq, input logic ra, input logic rb,
                                 input logic [11:0] p, input logic av, input logic [3:0] aid,
                                 input logic bv, input logic [3:0] bid, input logic bz,
                                 input logic t, input logic [7:0] g);
        vec_t v;
        v.req = rq; v.ra = ra; v.rb = rb; v.pend = p; v.av = av; v.aid = aid;
        v.bv = bv; v.bid = bid; v.busy = bz; v.to = t; v.grant = g;
        return v;
    endfunction

    vec_t vecs [17];

    initial begin
        int thr;
        logic [11:0] rq;

        // pair dispatch, both accept, single request, set-over-clear, re-dispatch, timeout
        vecs[0]  = row(12'h801, 1'b0, 1'b0, 12'h801, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        vecs[1]  = row(12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 4'd12, 1'b1, 4'd1, 1'b1, 1'b0, 8'd0);
        vecs[2]  = row(12'h000, 1'b1, 1'b1, 12'h000, 1'b0, 4'd12, 1'b0, 4'd1, 1'b0, 1'b0, 8'd2);
        vecs[3]  = row(12'h010, 1'b0, 1'b0, 12'h010, 1'b0, 4'd12, 1'b0, 4'd1, 1'b0, 1'b0, 8'd2);
        vecs[4]  = row(12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 4'd5,  1'b0, 4'd0, 1'b1, 1'b0, 8'd2);
        vecs[5]  = row(12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 4'd5,  1'b0, 4'd0, 1'b0, 1'b0, 8'd3);
        vecs[6]  = row(12'h008, 1'b0, 1'b0, 12'h008, 1'b0, 4'd5,  1'b0, 4'd0, 1'b0, 1'b0, 8'd3);
        vecs[7]  = row(12'h008, 1'b0, 1'b0, 12'h008, 1'b1, 4'd4,  1'b0, 4'd0, 1'b1, 1'b0, 8'd3);
        vecs[8]  = row(12'h000, 1'b1, 1'b0, 12'h008, 1'b0, 4'd4,  1'b0, 4'd0, 1'b0, 1'b0, 8'd4);
        vecs[9]  = row(12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 4'd4,  1'b0, 4'd0, 1'b1, 1'b0, 8'd4);
        vecs[10] = row(12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 4'd4,  1'b0, 4'd0, 1'b1, 1'b0, 8'd4);
        vecs[11] = row(12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 4'd4,  1'b0, 4'd0, 1'b1, 1'b0, 8'd4);
        vecs[12] = row(12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 4'd4,  1'b0, 4'd0, 1'b1, 1'b0, 8'd4);
        vecs[13] = row(12'h000, 1'b0, 1'b0, 12'h008, 1'b0, 4'd4,  1'b0, 4'd0, 1'b0, 1'b1, 8'd4);
        vecs[14] = row(12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 4'd4,  1'b0, 4'd0, 1'b1, 1'b0, 8'd4);
        vecs[15] = row(12'h000, 1'b0, 1'b1, 12'h000, 1'b1, 4'd4,  1'b0, 4'd0, 1'b1, 1'b0, 8'd4);
        vecs[16] = row(12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 4'd4,  1'b0, 4'd0, 1'b0, 1'b0, 8'd5);

        rst_n = 1'b0;
        req_i = '0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst pend", int'(pend), 0);
        check("rst a_valid", int'(a_valid), 0);
        check("rst b_valid", int'(b_valid), 0);
        check("rst a_id", int'(a_id), 0);
        check("rst b_id", int'(b_id), 0);
        check("rst busy", int'(busy), 0);
        check("rst timeout", int'(tmo), 0);
        check("rst grant", int'(grant), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            tick(vecs[i].req, vecs[i].ra, vecs[i].rb, 1'b0);
            check($sformatf("vec%0d pend", i),    int'(pend),    int'(vecs[i].pend));
            check($sformatf("vec%0d a_valid", i), int'(a_valid), int'(vecs[i].av));
            check($sformatf("vec%0d a_id", i),    int'(a_id),    int'(vecs[i].aid));
            check($sformatf("vec%0d b_valid", i), int'(b_valid), int'(vecs[i].bv));
            check($sformatf("vec%0d b_id", i),    int'(b_id),    int'(vecs[i].bid));
            check($sformatf("vec%0d busy", i),    int'(busy),    int'(vecs[i].busy));
            check($sformatf("vec%0d timeout", i), int'(tmo),     int'(vecs[i].to));
            check($sformatf("vec%0d grant", i),   int'(grant),   int'(vecs[i].grant));
        end

        // Asynchronous reset in the middle of an issue burst
        tick(12'h0c0, 1'b0, 1'b0, 1'b0);
        tick(12'h000, 1'b0, 1'b0, 1'b0);
        check("pre-rst a_valid", int'(a_valid), 1);
        check("pre-rst a_id", int'(a_id), 8);
        check("pre-rst b_id", int'(b_id), 7);
        req_i = 12'h020;
        #2;
        rst_n = 1'b0;
        #1;
        check("async a_valid", int'(a_valid), 0);
        check("async b_valid", int'(b_valid), 0);
        check("async pend", int'(pend), 0);
        check("async busy", int'(busy), 0);
        check("async grant", int'(grant), 0);
        req_i = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(12'h000, 1'b1, 1'b1, 1'b0);
        check("post-rst a_valid", int'(a_valid), 0);
        check("post-rst pend", int'(pend), 0);
        check("post-rst grant", int'(grant), 0);

        // Randomized traffic, alternating eager and sluggish consumers
        model_reset();
        thr = 70;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 64 == 0) thr = (thr == 70) ? 20 : 70;
            rq = ($urandom_range(0, 3) == 0) ? 12'($urandom) & 12'($urandom) : 12'h000;
            tick(rq, $urandom_range(0, 99) < thr, $urandom_range(0, 99) < thr, 1'b1);
            check($sformatf("rnd%0d pend", cyc),    int'(pend),    int'(m_pend));
            check($sformatf("rnd%0d a_valid", cyc), int'(a_valid), int'(m_act[0]));
            check($sformatf("rnd%0d b_valid", cyc), int'(b_valid), int'(m_act[1]));
            if (m_act[0]) check($sformatf("rnd%0d a_id", cyc), int'(a_id), m_id[0]);
            if (m_act[1]) check($sformatf("rnd%0d b_id", cyc), int'(b_id), m_id[1]);
            check($sformatf("rnd%0d busy", cyc),    int'(busy),    int'(m_act[0] || m_act[1]));
            check($sformatf("rnd%0d timeout", cyc), int'(tmo),     int'(m_to));
            check($sformatf("rnd%0d grant", cyc),   int'(grant),   m_grant % 256);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/req_dispatch.md
# req_dispatch

Request collection and dispatch stage wrapped around the dual priority encoder. It latches 12 sticky request lines into a pending vector and drives that vector to the encoder. It takes the encoder's two highest-priority indices back, issues them on two valid/ready service channels, and clears serviced requests. Channels left unaccepted past a timeout are re-queued.

## Interface
Parameters:
- TIMEOUT, 255: cycles a channel may stay valid without acceptance before its request is re-queued (1..65535).
- CNT_W, 8: width of the wrapping grant counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_i  input  12  request pulses; bit k sets pending bit k (index k+1).
- pend_o  output  12  registered pending vector, drives encoder input.
- first_i  input  4  encoder highest index (1..12, 0 = none); combinational from pend_o.
- second_i  input  4  encoder second index (1..12, 0 = none).
- a_valid_o  output  1  channel A valid.
- a_id_o  output  4  channel A index.
- a_ready_i  input  1  channel A accept.
- b_valid_o  output  1  channel B valid.
- b_id_o  output  4  channel B index.
- b_ready_i  input  1  channel B accept.
- busy_o  output  1  FSM not in IDLE.
- timeout_o  output  1  one-cycle pulse when any channel times out.
- grant_cnt_o  output  CNT_W  count of accepted handshakes, wraps.

## Operation
- Index encoding: id n (1..12) ↔ bit n-1; 0 = none. Bit 11 (id 12) is highest priority.
- Pending update per cycle: pend_next = (pend & ~clr) | req_i | requeue. Set wins over clear on the same bit.
- FSM states: IDLE, ISSUE.
- IDLE: if first_i != 0, capture a_id = first_i and b_id = second_i, then go to ISSUE.
  - b_valid is set only if second_i != 0 and second_i != first_i.
  - Clear the captured bits from pend in the same edge.
  - If first_i == 0, stay in IDLE; no outputs change.
- ISSUE: each channel holds valid and id stable until its ready is sampled high, then drops valid.
  - Return to IDLE on the edge where no channel remains valid.
  - Both accepted on the same edge → IDLE next cycle.
- Timeout: one 16-bit wait counter per channel, reset at capture and counting while valid && !ready.
  - At count == TIMEOUT-1 with ready low: drop valid, OR that id's bit into requeue, pulse timeout_o.
  - Ready high on that same edge is an accept, not a timeout.
- grant_cnt_o increments by 1 per accepted handshake, and by 2 when A and B accept on the same edge. It wraps modulo 2^CNT_W.
- Requests arriving during ISSUE accumulate in pend and are serviced at the next IDLE.
- Ready asserted while valid is low is ignored.

## Timing
- Reset values: pend_o = 0, a_valid_o = b_valid_o = 0, a_id_o = b_id_o = 0, busy_o = 0, timeout_o = 0, grant_cnt_o = 0, state = IDLE, wait counters = 0.
- Reset is asynchronous. Asserting it mid-ISSUE drops valids immediately and discards all pending and in-flight requests.
- req_i high in cycle N → pend_o bit set in N+1 → a_valid_o high in N+2 (latency 2 from IDLE).
- Accept at edge M → next capture at edge M+1 at the earliest, so valid is low for at least 1 cycle between bursts.
- Combinational loop path: pend_o (flop) → encoder → first_i/second_i → FSM flops; there is no combinational path from inputs to outputs.
- Timeout re-queue: the bit reappears in pend_o the cycle after the timeout edge.

## Structure
- Shared package holds: REQ_N = 12, ID_W = 4, ID_NONE = 4'h0, the FSM state enum, and an id-to-onehot function (id n → bit n-1, 0 → all zeros).
- One sub-module: req_chan, a single-channel valid/ready holder with wait counter and timeout. It is instantiated twice (A, B).
- The encoder is instantiated by the parent integration, not inside req_dispatch.

## Test plan
- Reset, then req_i = 12'h801 for one cycle → pend_o = 12'h801; 2 cycles after the pulse, a_id = 12 and b_id = 1 valid; pend_o = 0.
- Single request req_i = 12'h010 → a_id = 5, b_valid = 0; a_ready pulse → IDLE, grant_cnt = 1.
- Both readies high on the same edge → grant_cnt += 2, busy_o low next cycle.
- TIMEOUT = 4, a_ready held low → after 4 valid cycles a_valid drops, timeout_o pulses once, and the id's bit is set again in pend_o next cycle.
- req_i sets bit 3 (id 4) on the exact edge its captured bit is cleared → bit stays pending and is re-dispatched after the current ISSUE.
- rst_n low mid-ISSUE with a_valid high → a_valid_o = 0 asynchronously and pend_o = 0, with no grant counted.
